// File: rtl/two_flop_sync.sv
// Multi-bit flip-flop synchronizer: carries a slowly changing or Gray-coded bus
// (e.g. a FIFO pointer) from an unrelated source domain into the clk domain.
// Each bit passes independently through STAGES back-to-back flops; no logic is
// applied to the data, so multi-bit coherence relies on the sender changing at
// most one bit per transfer.
//
// Ports:
//   clk - destination-domain clock, rising-edge active
//   rst - asynchronous, active-high reset; loads RST_VAL into every stage
//   in  - asynchronous source-domain data, no timing relation to clk
//   Q   - synchronized data, driven directly by the last stage register
//
// Parameters:
//   WIDTH   - bus width of in and Q
//   STAGES  - number of register stages (must be >= 2)
//   RST_VAL - value held by every stage while rst is high
module two_flop_sync #(
    parameter int unsigned       WIDTH   = 4,
    parameter int unsigned       STAGES  = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] Q
);

    // A single stage gives no metastability settling time, so refuse to build.
    if (STAGES < 2) begin : g_bad_stages
        $error("two_flop_sync: STAGES must be >= 2");
    end

    // Synchronizer chain; the attribute keeps the flops adjacent and un-retimed.
    (* ASYNC_REG = "TRUE" *)
    logic [STAGES-1:0][WIDTH-1:0] sync;

    // First stage samples the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync[0] <= RST_VAL;
        end else begin
            sync[0] <= in;
        end
    end

    // Remaining stages are plain flop-to-flop shifts with nothing in between.
    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync[i] <= RST_VAL;
            end else begin
                sync[i] <= sync[i-1];
            end
        end
    end

    // Output comes straight from the last register.
    assign Q = sync[STAGES-1];

endmodule

// File: tb/tb_two_flop_sync.sv
// Directed bench for two_flop_sync: default 4-bit/2-stage instance plus an
// 8-bit/3-stage instance with a non-zero reset value.
module tb_two_flop_sync;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic [3:0] q;

    logic       rst8;
    logic [7:0] in8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    two_flop_sync dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .Q   (q)
    );

    two_flop_sync #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'h5A)
    ) dut8 (
        .clk (clk),
        .rst (rst8),
        .in  (in8),
        .Q   (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [3:0] seq [8];

    initial begin
        seq[0] = 4'd6;  seq[1] = 4'd9; seq[2] = 4'd12; seq[3] = 4'd3;
        seq[4] = 4'd2;  seq[5] = 4'd5; seq[6] = 4'd1;  seq[7] = 4'd13;

        rst  = 1'b0;
        in   = 4'd0;
        rst8 = 1'b0;
        in8  = 8'hC3;

        // Reset pulse t=2..4 (default), t=2..8 (parameterized instance)
        #2;
        rst  = 1'b1;
        rst8 = 1'b1;
        #1;
        check("rst_async", 32'(q), 32'h0);
        check("rst_async8", 32'(q8), 32'h5A);
        #1;
        rst = 1'b0;
        #2; // t=6, just after posedge at 5
        check("rst_hold", 32'(q), 32'h0);
        check("rst_hold8", 32'(q8), 32'h5A);
        #2; // t=8
        rst8 = 1'b0;

        // Sequence: drive on negedge, sample 1 after posedge
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in = seq[k];
            @(posedge clk);
            #1;
            check("seq", 32'(q), (k == 0) ? 32'h0 : 32'(seq[k-1]));
            if (k < 2)
                check("p8_latency", 32'(q8), 32'h5A);
            else if (k == 2)
                check("p8_arrive", 32'(q8), 32'hC3);
        end
        @(posedge clk);
        #1;
        check("seq_last", 32'(q), 32'hD);

        // Hold 4'hA for 5 cycles, checking both edges for stability
        @(negedge clk);
        in = 4'hA;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_edge", 32'(q), (c == 0) ? 32'hD : 32'hA);
            @(negedge clk);
            check("hold_mid", 32'(q), (c == 0) ? 32'hD : 32'hA);
        end

        // Mid-stream reset with 4'hF streaming
        in = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stream_f", 32'(q), 32'hF);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst", 32'(q), 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_e1", 32'(q), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_e2", 32'(q), 32'hF);

        // Parameterized instance: steady value survives, then mid reset
        check("p8_steady", 32'(q8), 32'hC3);
        #1;
        rst8 = 1'b1;
        #1;
        check("p8_mid_rst", 32'(q8), 32'h5A);
        rst8 = 1'b0;
        @(posedge clk);
        #1;
        check("p8_post_e1", 32'(q8), 32'h5A);
        @(posedge clk);
        #1;
        check("p8_post_e2", 32'(q8), 32'h5A);
        @(posedge clk);
        #1;
        check("p8_post_e3", 32'(q8), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
